videocard_loader: RTL and testbench

Host-side loader that sits directly upstream of `videocard_top`. It takes a word stream (program image, then data image), writes it into the videocard memory port, starts the engine through the control port, and polls the status register until the engine finishes. It replaces the manual "write code at 65536+, write data at 0+, write 1 to control 0, watch control 1" sequence with one `start` pulse.

---
 rtl/videocard_loader.sv | 213 +++++++++++++++++++++
 tb/tb_videocard_loader.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/videocard_loader.sv
// Host-side loader for videocard_top: streams the program and data images into the
// memory port, kicks the engine through the control port and polls until it stops.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | waiting for start; lengths latched on the start cycle
// S_LOAD_CODE | accepting code words, writing from CODE_BASE upward
// S_LOAD_DATA | accepting data words, writing from DATA_BASE upward
// S_KICK      | write 1 to control register 0 (strobe appears next cycle)
// S_SETTLE    | POLL_DELAY cycles of status reads before sampling begins
// S_POLL      | sample status bit0 each cycle until the engine reports idle
// S_FIN       | one cycle of done, busy already low

module videocard_loader #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 17,
    parameter int CODE_BASE  = 65536,
    parameter int DATA_BASE  = 0,
    parameter int POLL_DELAY = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [15:0]           code_len,
    input  logic [15:0]           data_len,
    input  logic [WIDTH-1:0]      s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [ADDR_WIDTH-1:0] vc_address,
    output logic [WIDTH-1:0]      vc_data_in,
    output logic                  vc_write,
    output logic [3:0]            vc_byteenable,
    output logic                  vc_address_control,
    output logic [WIDTH-1:0]      vc_data_in_control,
    output logic                  vc_write_control,
    output logic                  vc_read_control,
    input  logic [WIDTH-1:0]      vc_data_out_control,
    output logic                  busy,
    output logic                  done
);

    localparam int DLY_W = (POLL_DELAY > 1) ? $clog2(POLL_DELAY) : 1;
    localparam logic [DLY_W-1:0]      DLY_LOAD   = DLY_W'((POLL_DELAY > 0) ? POLL_DELAY - 1 : 0);
    localparam logic [ADDR_WIDTH-1:0] CODE_START = ADDR_WIDTH'(CODE_BASE);
    localparam logic [ADDR_WIDTH-1:0] DATA_START = ADDR_WIDTH'(DATA_BASE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_CODE,
        S_LOAD_DATA,
        S_KICK,
        S_SETTLE,
        S_POLL,
        S_FIN
    } state_t;

    state_t                  state, state_d;
    logic [ADDR_WIDTH-1:0]   addr_cnt, addr_d;
    logic [15:0]             code_rem, code_rem_d;
    logic [15:0]             data_rem, data_rem_d;
    logic [DLY_W-1:0]        dly_cnt, dly_d;

    logic                    hs;
    logic                    ready_d;
    logic [ADDR_WIDTH-1:0]   vaddr_d;
    logic [WIDTH-1:0]        vdata_d;
    logic                    wr_d;
    logic                    actl_d;
    logic [WIDTH-1:0]        dctl_d;
    logic                    wctl_d;
    logic                    rctl_d;
    logic                    busy_d;
    logic                    done_d;

    // Only the run flag of the status word matters.
    logic unused_status_bits;
    assign unused_status_bits = ^vc_data_out_control[WIDTH-1:1];

    assign vc_byteenable = 4'b1111;
    assign hs = s_valid & s_ready;

    always_comb begin
        state_d    = state;
        addr_d     = addr_cnt;
        code_rem_d = code_rem;
        data_rem_d = data_rem;
        dly_d      = dly_cnt;
        wr_d       = 1'b0;
        vaddr_d    = vc_address;
        vdata_d    = vc_data_in;
        actl_d     = 1'b0;
        dctl_d     = '0;
        wctl_d     = 1'b0;
        rctl_d     = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    code_rem_d = code_len;
                    data_rem_d = data_len;
                    addr_d     = CODE_START;
                    if (code_len != 16'd0) begin
                        state_d = S_LOAD_CODE;
                    end else if (data_len != 16'd0) begin
                        state_d = S_LOAD_DATA;
                        addr_d  = DATA_START;
                    end else begin
                        state_d = S_KICK;
                    end
                end
            end
            S_LOAD_CODE: begin
                if (hs) begin
                    wr_d       = 1'b1;
                    vaddr_d    = addr_cnt;
                    vdata_d    = s_data;
                    addr_d     = addr_cnt + 1'b1;
                    code_rem_d = code_rem - 16'd1;
                    if (code_rem == 16'd1) begin
                        if (data_rem != 16'd0) begin
                            state_d = S_LOAD_DATA;
                            addr_d  = DATA_START;
                        end else begin
                            state_d = S_KICK;
                        end
                    end
                end
            end
            S_LOAD_DATA: begin
                if (hs) begin
                    wr_d       = 1'b1;
                    vaddr_d    = addr_cnt;
                    vdata_d    = s_data;
                    addr_d     = addr_cnt + 1'b1;
                    data_rem_d = data_rem - 16'd1;
                    if (data_rem == 16'd1) begin
                        state_d = S_KICK;
                    end
                end
            end
            S_KICK: begin
                wctl_d  = 1'b1;
                dctl_d  = WIDTH'(1);
                dly_d   = DLY_LOAD;
                state_d = (POLL_DELAY == 0) ? S_POLL : S_SETTLE;
            end
            S_SETTLE: begin
                actl_d = 1'b1;
                rctl_d = 1'b1;
                if (dly_cnt == '0) begin
                    state_d = S_POLL;
                end else begin
                    dly_d = dly_cnt - 1'b1;
                end
            end
            S_POLL: begin
                actl_d = 1'b1;
                rctl_d = 1'b1;
                if (!vc_data_out_control[0]) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Handshake-facing flags follow the next state so they line up with the edge that caused them.
        ready_d = (state_d == S_LOAD_CODE) || (state_d == S_LOAD_DATA);
        busy_d  = (state_d != S_IDLE) && (state_d != S_FIN);
        done_d  = (state_d == S_FIN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state              <= S_IDLE;
            addr_cnt           <= '0;
            code_rem           <= '0;
            data_rem           <= '0;
            dly_cnt            <= '0;
            s_ready            <= 1'b0;
            vc_address         <= '0;
            vc_data_in         <= '0;
            vc_write           <= 1'b0;
            vc_address_control <= 1'b0;
            vc_data_in_control <= '0;
            vc_write_control   <= 1'b0;
            vc_read_control    <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
        end else begin
            state              <= state_d;
            addr_cnt           <= addr_d;
            code_rem           <= code_rem_d;
            data_rem           <= data_rem_d;
            dly_cnt            <= dly_d;
            s_ready            <= ready_d;
            vc_address         <= vaddr_d;
            vc_data_in         <= vdata_d;
            vc_write           <= wr_d;
            vc_address_control <= actl_d;
            vc_data_in_control <= dctl_d;
            vc_write_control   <= wctl_d;
            vc_read_control    <= rctl_d;
            busy               <= busy_d;
            done               <= done_d;
        end
    end

endmodule

// File: tb/tb_videocard_loader.sv
// Randomized bench for videocard_loader: a job-level reference model predicts every
// memory write, the kick cycle and the done cycle; a status stub emulates the engine.

module tb_videocard_loader;

    localparam int W         = 32;
    localparam int AW        = 17;
    localparam int PD        = 8;
    localparam int CODE_MAIN = 65536;
    localparam int CODE_WRAP = 'h1FFFE;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start, sel_wrap;
    logic          start_main, start_wrap;
    logic [15:0]   code_len, data_len;
    logic [W-1:0]  s_data;
    logic          s_valid;
    logic [W-1:0]  vc_data_out_control;

    logic          m_ready, m_write, m_actl, m_wctl, m_rctl, m_busy, m_done;
    logic [AW-1:0] m_address;
    logic [W-1:0]  m_data_in, m_dctl;
    logic [3:0]    m_be;
    logic          w_ready, w_write, w_actl, w_wctl, w_rctl, w_busy, w_done;
    logic [AW-1:0] w_address;
    logic [W-1:0]  w_data_in, w_dctl;
    logic [3:0]    w_be;

    always #5 clk = ~clk;

    assign start_main = start & ~sel_wrap;
    assign start_wrap = start & sel_wrap;

    videocard_loader #(.CODE_BASE(CODE_MAIN)) dut (
        .clk(clk), .reset_n(reset_n), .start(start_main),
        .code_len(code_len), .data_len(data_len),
        .s_data(s_data), .s_valid(s_valid), .s_ready(m_ready),
        .vc_address(m_address), .vc_data_in(m_data_in), .vc_write(m_write),
        .vc_byteenable(m_be), .vc_address_control(m_actl),
        .vc_data_in_control(m_dctl), .vc_write_control(m_wctl),
        .vc_read_control(m_rctl), .vc_data_out_control(vc_data_out_control),
        .busy(m_busy), .done(m_done)
    );

    // Second instance whose code region starts two words below the top of the address space.
    videocard_loader #(.CODE_BASE(CODE_WRAP)) dut_wrap (
        .clk(clk), .reset_n(reset_n), .start(start_wrap),
        .code_len(code_len), .data_len(data_len),
        .s_data(s_data), .s_valid(s_valid), .s_ready(w_ready),
        .vc_address(w_address), .vc_data_in(w_data_in), .vc_write(w_write),
        .vc_byteenable(w_be), .vc_address_control(w_actl),
        .vc_data_in_control(w_dctl), .vc_write_control(w_wctl),
        .vc_read_control(w_rctl), .vc_data_out_control(vc_data_out_control),
        .busy(w_busy), .done(w_done)
    );

    logic          o_ready, o_write, o_actl, o_wctl, o_rctl, o_busy, o_done;
    logic [AW-1:0] o_address;
    logic [W-1:0]  o_data_in, o_dctl;
    logic [3:0]    o_be;

    assign o_ready   = sel_wrap ? w_ready   : m_ready;
    assign o_write   = sel_wrap ? w_write   : m_write;
    assign o_actl    = sel_wrap ? w_actl    : m_actl;
    assign o_wctl    = sel_wrap ? w_wctl    : m_wctl;
    assign o_rctl    = sel_wrap ? w_rctl    : m_rctl;
    assign o_busy    = sel_wrap ? w_busy    : m_busy;
    assign o_done    = sel_wrap ? w_done    : m_done;
    assign o_address = sel_wrap ? w_address : m_address;
    assign o_data_in = sel_wrap ? w_data_in : m_data_in;
    assign o_dctl    = sel_wrap ? w_dctl    : m_dctl;
    assign o_be      = sel_wrap ? w_be      : m_be;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int            wr_cyc[$];
    logic [AW-1:0] wr_addr[$];
    logic [W-1:0]  wr_data[$];
    int            kick_cyc[$];
    int            done_cyc[$];
    int            kick_bad, overlap, busy_at_done;
    int            hold_len;

    // Observation happens mid-cycle; the status stub then reports "running" for
    // hold_len cycles starting the cycle after the observed kick strobe.
    always @(negedge clk) begin
        logic [W-1:0] st;
        if (reset_n) begin
            if (o_write) begin
                wr_cyc.push_back(cyc);
                wr_addr.push_back(o_address);
                wr_data.push_back(o_data_in);
            end
            if (o_wctl) begin
                kick_cyc.push_back(cyc);
                if (o_actl !== 1'b0 || o_dctl !== W'(1)) kick_bad++;
            end
            if (o_wctl && o_rctl) overlap++;
            if (o_done) begin
                done_cyc.push_back(cyc);
                if (o_busy) busy_at_done++;
            end
        end
        st = $urandom;
        st[0] = 1'b0;
        if (kick_cyc.size() > 0)
            st[0] = (cyc >= kick_cyc[kick_cyc.size()-1] + 1) &&
                    (cyc <= kick_cyc[kick_cyc.size()-1] + hold_len);
        vc_data_out_control = st;
    end

    task automatic run_job(input string nm, input int cl, input int dl, input int vmode,
                           input int hold, input bit poke);
        int            total = cl + dl;
        int            base = sel_wrap ? CODE_WRAP : CODE_MAIN;
        logic [W-1:0]  words[$];
        logic [AW-1:0] eaddr[$];
        int            ewcyc[$];
        int            idx = 0;
        bit            hsp = 1'b0;
        bit            v;
        bit            poked1 = 1'b0, poked2 = 1'b0;
        int            start_edge;
        int            read_cnt = 0;
        int            after_done = -1;
        int            k, k_exp, z, nchk;

        for (int i = 0; i < cl; i++) begin
            eaddr.push_back(AW'(base + i));
            words.push_back($urandom);
        end
        for (int j = 0; j < dl; j++) begin
            eaddr.push_back(AW'(j));
            words.push_back($urandom);
        end
        wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
        kick_cyc.delete(); done_cyc.delete();
        kick_bad = 0; overlap = 0; busy_at_done = 0;
        hold_len = hold;

        @(negedge clk);
        code_len   = 16'(cl);
        data_len   = 16'(dl);
        start      = 1'b1;
        start_edge = cyc + 1;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == start_edge) begin
                chk({nm, " busy_after_start"}, o_busy, 1);
                chk({nm, " ready_after_start"}, o_ready, (total != 0));
            end
            if (hsp) begin
                ewcyc.push_back(cyc);
                idx++;
                if (idx == total) chk({nm, " ready_drop"}, o_ready, 0);
            end
            if (vmode == 0)      v = 1'b1;
            else if (vmode == 1) v = (n % 3 == 0);
            else                 v = 1'($urandom_range(0, 1));
            s_valid = v && (idx < total);
            if (s_valid) s_data = words[idx];
            else         s_data = $urandom;
            hsp = s_valid && o_ready;
            if (o_rctl) read_cnt++;
            if (poke && !poked1 && idx > cl && idx < total) begin
                start = 1'b1; poked1 = 1'b1;
                code_len = 16'($urandom); data_len = 16'($urandom);
            end
            if (poke && !poked2 && read_cnt == PD + 2) begin
                start = 1'b1; poked2 = 1'b1;
                code_len = 16'($urandom); data_len = 16'($urandom);
            end
            if (done_cyc.size() > 0 && after_done < 0) after_done = 0;
            if (after_done >= 0) after_done++;
            if (after_done > 4) break;
        end
        s_valid = 1'b0;
        start   = 1'b0;

        chk({nm, " finished"}, (done_cyc.size() > 0), 1);
        chk({nm, " write_count"}, wr_cyc.size(), total);
        nchk = (wr_cyc.size() < total) ? wr_cyc.size() : total;
        for (int i = 0; i < nchk; i++) begin
            chk({nm, " wr_addr"}, wr_addr[i], eaddr[i]);
            chk({nm, " wr_data"}, wr_data[i], words[i]);
            if (i < ewcyc.size()) chk({nm, " wr_cycle"}, wr_cyc[i], ewcyc[i]);
        end
        chk({nm, " kick_count"}, kick_cyc.size(), 1);
        chk({nm, " kick_fields"}, kick_bad, 0);
        chk({nm, " ctl_overlap"}, overlap, 0);
        if (kick_cyc.size() > 0) begin
            k = kick_cyc[0];
            if (total == 0)            k_exp = start_edge + 1;
            else if (ewcyc.size() > 0) k_exp = ewcyc[ewcyc.size()-1] + 1;
            else                       k_exp = -1;
            chk({nm, " kick_cycle"}, k, k_exp);
            z = (k + hold + 1 > k + PD) ? k + hold + 1 : k + PD;
            if (done_cyc.size() > 0) chk({nm, " done_cycle"}, done_cyc[0], z + 1);
        end
        chk({nm, " done_count"}, done_cyc.size(), 1);
        chk({nm, " busy_at_done"}, busy_at_done, 0);
        chk({nm, " busy_after"}, o_busy, 0);
    endtask

    task automatic chk_reset_values(input string nm);
        chk({nm, " s_ready"}, o_ready, 0);
        chk({nm, " vc_address"}, o_address, 0);
        chk({nm, " vc_data_in"}, o_data_in, 0);
        chk({nm, " vc_write"}, o_write, 0);
        chk({nm, " byteenable"}, o_be, 4'hF);
        chk({nm, " addr_ctl"}, o_actl, 0);
        chk({nm, " data_ctl"}, o_dctl, 0);
        chk({nm, " write_ctl"}, o_wctl, 0);
        chk({nm, " read_ctl"}, o_rctl, 0);
        chk({nm, " busy"}, o_busy, 0);
        chk({nm, " done"}, o_done, 0);
    endtask

    initial begin
        int wcount;
        reset_n  = 1'b0;
        start    = 1'b0;
        sel_wrap = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;
        code_len = '0;
        data_len = '0;
        hold_len = 20;
        repeat (3) @(negedge clk);
        chk_reset_values("reset");
        reset_n = 1'b1;

        run_job("nominal", 3, 2, 0, 20, 1'b0);
        run_job("backpressure", 3, 2, 1, 20, 1'b0);
        run_job("data_only", 0, 2, 0, 20, 1'b0);
        run_job("empty", 0, 0, 0, 20, 1'b0);
        run_job("code_only_short_hold", 2, 0, 0, 3, 1'b0);
        run_job("start_while_busy", 3, 4, 2, 20, 1'b1);
        for (int r = 0; r < 4; r++)
            run_job("random", $urandom_range(0, 6), $urandom_range(0, 6), 2,
                    $urandom_range(0, 25), 1'b0);

        @(negedge clk);
        code_len = 16'd3;
        data_len = 16'd2;
        start    = 1'b1;
        wcount   = 0;
        for (int n = 0; n < 20 && wcount < 2; n++) begin
            @(negedge clk);
            start   = 1'b0;
            s_valid = 1'b1;
            s_data  = $urandom;
            if (o_write) wcount++;
        end
        chk("midload two_writes", wcount, 2);
        #2 reset_n = 1'b0;
        #1 chk_reset_values("midload_reset");
        s_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        run_job("after_reset", 3, 2, 0, 20, 1'b0);

        @(negedge clk);
        sel_wrap = 1'b1;
        run_job("wrap", 3, 1, 0, 20, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
